bit_transition_sequencer: RTL and testbench
===========================================

Name: bit_transition_sequencer

Overview:
- Controller that sequences parallel words through the team's single-bit change detector.
- Accepts a WIDTH-bit word on a valid/ready handshake and shifts it one bit per cycle into an internal registered change detector.
- Counts detected transitions and returns the count on a second valid/ready handshake.
- Sits between a word-oriented producer and the serial edge-detect datapath, and owns its sequencing.

Parameters:
- WIDTH, 8, bits per input word (2..32).
- CNT_W, $clog2(WIDTH+1), width of the transition count (holds 0..WIDTH).
- MSB_FIRST, 1, 1 = shift bit WIDTH-1 first; 0 = shift bit 0 first.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input word valid.
- in_ready  output  1  block can accept a word.
- in_data  input  WIDTH  word to serialise.
- out_valid  output  1  count valid.
- out_ready  input  1  consumer accepts the count.
- out_count  output  CNT_W  number of transitions in the last word.
- busy  output  1  high in any state other than IDLE.
- ser_bit  output  1  bit currently presented to the detector (debug).
- ser_flag  output  1  registered detector flag (debug).

Behaviour:
- Reset is synchronous and active-high on rst, clocked by clk. On reset:
  - state=IDLE, in_ready=1, out_valid=0, out_count=0, busy=0, ser_bit=0, ser_flag=0.
  - Bit index=0.
  - Reference level=1.
- Detector (sub-module):
  - One register holding the previous bit (reset 1) and one registered flag.
  - Each enabled cycle: flag<=(bit != prev), prev<=bit.
  - Latency 1: the flag for a bit is visible the cycle after the bit is presented.
- Reference carry:
  - The first bit of a word is compared against the last bit of the previous word (or 1 after reset).
  - The detector's prev register is never cleared between words.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch in_data, bit index<=0, count<=0, go to SHIFT.
- SHIFT:
  - Lasts exactly WIDTH cycles. Each cycle presents the next bit (order per MSB_FIRST) with detector enable=1, and bit index increments.
  - count<=count+flag on every edge where the flag belongs to a bit of the current word; a one-bit valid pipeline tracks this.
  - After the last bit is presented, go to DRAIN.
- DRAIN:
  - Lasts one cycle, detector enable=0.
  - Adds the final flag, then goes to DONE.
- DONE:
  - out_valid=1 and out_count is stable.
  - On out_ready: out_valid<=0, go to IDLE.
- Latency: a word accepted on edge N gives out_valid=1 after edge N+WIDTH+2.
- in_ready=0 in SHIFT, DRAIN and DONE. in_valid there is ignored and the word is not latched.
- No bypass: the DONE→IDLE edge does not accept a new word; the earliest accept is the following edge.
- out_valid held high indefinitely while out_ready=0. out_count must not change.
- out_ready while not in DONE has no effect.
- Count saturation is impossible (max WIDTH fits CNT_W). Arithmetic is unsigned.
- Reset mid-operation (any state):
  - Abort the word and return to IDLE with the reset values above.
  - Discard the partial count. Reference level returns to 1.
- Unreachable state encodings fall back to IDLE with outputs at their reset values.

Decomposition:
- Shared package bts_pkg:
  - State enum (IDLE, SHIFT, DRAIN, DONE, 2-bit).
  - Reset-reference constant REF_INIT=1'b1.
  - Default WIDTH.
- One natural sub-module: bit_change_det (clk, rst, en, bit_in, flag_out). Registered change flag with prev reset to 1.
- The sequencer instantiates it once and holds the FSM, shift index and counter.

Test Plan:
- Reset: assert rst 2 cycles → in_ready=1, out_valid=0, out_count=0, busy=0, ser_flag=0.
- Accept 0x55, MSB first, ref 1 → out_valid high 10 cycles after the accept edge, out_count=8. Stored reference becomes 1.
- Carry across words: 0x00 then 0xFF → counts 1 then 1. The second word's first bit is compared with 0, not 1.
- Backpressure: 0xFF with out_ready=0 for 5 cycles and in_valid=1 throughout → out_valid and out_count=0 held, in_ready=0, no second word latched; accepted on the first cycle after out_ready=1.
- Reset mid-SHIFT: accept 0x0F, assert rst after 3 bits → IDLE next cycle, out_valid never asserts. Then 0x55 → out_count=8, proving ref=1.
- MSB_FIRST=0 build: accept 0x0F (stream 1,1,1,1,0,0,0,0), ref 1 → out_count=1.

Source files
------------

// File: rtl/bts_pkg.sv
// Shared constants for the bit transition sequencer: FSM encodings,
// detector reference level and the default word width.
package bts_pkg;

  localparam int DEFAULT_WIDTH = 8;

  // Level the detector compares the very first bit against after reset.
  localparam logic REF_INIT = 1'b1;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_SHIFT = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

endpackage

// File: rtl/bit_change_det.sv
// Single-bit change detector: registered flag set when the enabled input
// differs from the previously enabled input. prev survives across words.
module bit_change_det
  import bts_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic bit_in,
  output logic flag_out
);

  logic prev_q;
  logic flag_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= REF_INIT;
      flag_q <= 1'b0;
    end else if (en) begin
      flag_q <= bit_in ^ prev_q;
      prev_q <= bit_in;
    end
  end

  assign flag_out = flag_q;

endmodule

// File: rtl/bit_transition_sequencer.sv
// Serialises a parallel word into bit_change_det and returns the number
// of transitions seen over a valid/ready output handshake.
module bit_transition_sequencer
  import bts_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int CNT_W     = $clog2(WIDTH + 1),
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_count,
  output logic             busy,
  output logic             ser_bit,
  output logic             ser_flag
);

  localparam int IDX_W = $clog2(WIDTH);

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // in_ready is high only in IDLE; out_valid is a register that rises one
  // edge after DONE is entered and holds until out_ready is seen.
  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               vld_q, vld_d;
  logic               out_valid_q, out_valid_d;
  logic [IDX_W-1:0]   sel_idx;
  logic               det_en;
  logic               det_bit;
  logic               det_flag;

  always_comb begin
    sel_idx = MSB_FIRST ? (IDX_W'(WIDTH - 1) - idx_q) : idx_q;
    det_bit = (state_q == ST_SHIFT) ? data_q[sel_idx] : 1'b0;
  end

  bit_change_det u_det (
    .clk      (clk),
    .rst      (rst),
    .en       (det_en),
    .bit_in   (det_bit),
    .flag_out (det_flag)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    data_d      = data_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    det_en      = 1'b0;
    // vld_q marks that det_flag belongs to a bit of the current word.
    if (vld_q) begin
      count_d = count_q + CNT_W'(det_flag);
    end
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          data_d  = in_data;
          idx_d   = '0;
          count_d = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        det_en = 1'b1;
        idx_d  = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(WIDTH - 1)) begin
          idx_d   = '0;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        state_d = ST_DONE;
      end
      ST_DONE: begin
        out_valid_d = 1'b1;
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        idx_d       = '0;
        count_d     = '0;
        out_valid_d = 1'b0;
      end
    endcase
    vld_d = det_en;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      data_q      <= '0;
      count_q     <= '0;
      vld_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      data_q      <= data_d;
      count_q     <= count_d;
      vld_q       <= vld_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = out_valid_q;
  assign out_count = count_q;
  assign ser_bit   = det_bit;
  assign ser_flag  = det_flag;

endmodule

// File: tb/tb_bit_transition_sequencer.sv
// Bench for bit_transition_sequencer: scoreboarded counts and latency on an
// MSB-first instance, plus a directed LSB-first instance.
module tb_bit_transition_sequencer;

  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, out_valid, out_ready, busy, ser_bit, ser_flag;
  logic [W-1:0]  in_data;
  logic [CW-1:0] out_count;
  logic          l_in_valid, l_in_ready, l_out_valid, l_out_ready, l_busy, l_ser_bit, l_ser_flag;
  logic [W-1:0]  l_in_data;
  logic [CW-1:0] l_out_count;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int hs_cyc   = 0;
  logic          model_ref;
  logic          prev_ov = 1'b0;
  logic [CW-1:0] exp_q[$];
  int            lat_q[$];

  bit_transition_sequencer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_count(out_count),
    .busy(busy), .ser_bit(ser_bit), .ser_flag(ser_flag)
  );

  bit_transition_sequencer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .in_valid(l_in_valid), .in_ready(l_in_ready), .in_data(l_in_data),
    .out_valid(l_out_valid), .out_ready(l_out_ready), .out_count(l_out_count),
    .busy(l_busy), .ser_bit(l_ser_bit), .ser_flag(l_ser_flag)
  );

  // Clock and reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int trans(input logic [W-1:0] w, input bit msb, input logic r0);
    logic r;
    int   c;
    r = r0;
    c = 0;
    for (int i = 0; i < W; i++) begin
      logic b;
      b = msb ? w[W-1-i] : w[i];
      if (b != r) c++;
      r = b;
    end
    return c;
  endfunction

  task automatic do_reset(input int n);
    rst = 1'b1;
    exp_q.delete();
    lat_q.delete();
    model_ref = 1'b1;
    repeat (n) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Driver: offers a word until accepted, records expectations on accept.
  task automatic send(input logic [W-1:0] d, output int acc_cyc);
    int n;
    n = 0;
    acc_cyc = -1;
    @(posedge clk) #1;
    in_valid = 1'b1;
    in_data  = d;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 200) begin
        check_val("accept_timeout", 0, 1);
        in_valid = 1'b0;
        return;
      end
    end
    acc_cyc = cyc + 1;
    exp_q.push_back(CW'(trans(d, 1'b1, model_ref)));
    model_ref = d[0];
    lat_q.push_back(acc_cyc + W + 2);
    @(posedge clk) #1;
    in_valid = 1'b0;
    check_val("busy_after_accept", busy, 1);
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() > 0) check_val("drain_timeout", exp_q.size(), 0);
    @(negedge clk);
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && !prev_ov) begin
        if (lat_q.size() > 0) check_val("latency", cyc, lat_q.pop_front());
        else check_val("unexpected_valid", 1, 0);
      end
      if (out_valid && out_ready) begin
        hs_cyc = cyc + 1;
        if (exp_q.size() > 0) check_val("count", out_count, exp_q.pop_front());
        else check_val("unexpected_output", 1, 0);
      end
    end
    prev_ov = out_valid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog checks=%0d", checks);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    int acc;
    int seen;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    l_in_valid = 1'b0; l_in_data = '0; l_out_ready = 1'b1;
    do_reset(2);
    @(negedge clk);
    check_val("rst_in_ready", in_ready, 1);
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_out_count", out_count, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_ser_flag", ser_flag, 0);
    check_val("rst_ser_bit", ser_bit, 0);

    // Alternating word, then reference carry across words
    send(8'h55, acc); wait_empty();
    send(8'h00, acc); wait_empty();
    send(8'hFF, acc); wait_empty();
    for (int i = 0; i < 3; i++) begin
      send(W'($urandom_range(0, 255)), acc);
      wait_empty();
    end

    // Backpressure: restore reference 1, then hold out_ready low
    send(8'hFF, acc); wait_empty();
    out_ready = 1'b0;
    send(8'hFF, acc);
    in_valid = 1'b1;
    in_data  = 8'h55;
    seen = 0;
    while (!out_valid && seen < 50) begin
      @(negedge clk);
      seen++;
    end
    check_val("bp_valid_seen", out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      check_val("bp_hold_valid", out_valid, 1);
      check_val("bp_hold_count", out_count, exp_q.size() > 0 ? 32'(exp_q[0]) : 32'hFFFF);
      check_val("bp_in_ready", in_ready, 0);
      @(negedge clk);
    end
    @(posedge clk) #1;
    out_ready = 1'b1;
    send(8'h55, acc);
    check_val("bp_accept_edge", acc, hs_cyc + 1);
    wait_empty();

    // Reset in the middle of SHIFT
    send(8'h0F, acc);
    @(posedge clk);
    @(posedge clk) #1;
    do_reset(1);
    @(negedge clk);
    check_val("midrst_busy", busy, 0);
    check_val("midrst_in_ready", in_ready, 1);
    seen = 0;
    for (int i = 0; i < W + 4; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check_val("midrst_no_valid", seen, 0);
    send(8'h55, acc); wait_empty();

    // LSB-first instance
    @(posedge clk) #1;
    l_in_valid = 1'b1;
    l_in_data  = 8'h0F;
    seen = 0;
    while (!l_in_ready && seen < 50) begin
      @(negedge clk);
      seen++;
    end
    @(negedge clk);
    @(posedge clk) #1;
    l_in_valid = 1'b0;
    seen = 0;
    while (!l_out_valid && seen < 50) begin
      @(negedge clk);
      seen++;
    end
    check_val("lsb_valid", l_out_valid, 1);
    check_val("lsb_count", l_out_count, trans(8'h0F, 1'b0, 1'b1));

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
